// File: rtl/spwf_memory_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spwf_memory_sequencer
//  Description : Sole master of a single-port write-first block RAM. Streams
//                words into consecutive addresses and streams an address
//                range back out, hiding the RAM's one-cycle read latency
//                behind a 2-entry output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module spwf_memory_sequencer #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   // commands
   input  logic                  start_write,
   input  logic [ADDR_WIDTH-1:0] write_base,
   input  logic                  start_read,
   input  logic [ADDR_WIDTH-1:0] read_base,
   input  logic [ADDR_WIDTH:0]   read_count,
   // write stream
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   // read stream
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   // status
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   words_written,
   // RAM pins
   output logic                  mem_enable,
   output logic                  mem_write_enable,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   C_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   C_DEPTH_M1 = {1'b0, {ADDR_WIDTH{1'b1}}};

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic [ADDR_WIDTH:0]   r_words;
   logic                  r_done;

   // read pipeline: a read issued this cycle has its data on mem_data_out
   // during the next cycle, where r_inflight marks it for capture
   logic                  r_inflight;
   logic                  r_inflight_last;

   // 2-entry output buffer, each entry tagged with its "final word" flag
   logic [DATA_WIDTH-1:0] r_buf_data [2];
   logic [1:0]            r_buf_last;
   logic                  r_head;
   logic [1:0]            r_count;

   logic                  w_wr_fire;
   logic                  w_pop;
   logic                  w_issue;
   logic                  w_tail;
   logic                  w_head_last;
   logic [1:0]            w_occupancy;

   assign w_wr_fire   = (r_state == ST_WRITE) && in_valid;
   assign w_pop       = (r_count != 2'd0) && out_ready;
   assign w_tail      = r_head ^ r_count[0];
   assign w_head_last = (r_count != 2'd0) && r_buf_last[r_head];

   // Occupancy is taken after this cycle's pop so that a word leaving the
   // buffer frees its slot immediately; this is what keeps a steady stream
   // at one word per cycle while never holding more than two words.
   assign w_occupancy = r_count - {1'b0, w_pop} + {1'b0, r_inflight};
   assign w_issue     = (r_state == ST_READ) && (r_remaining != '0) &&
                        (w_occupancy < 2'd2);

   // Stream and status outputs, all derived from registered state
   assign in_ready      = (r_state == ST_WRITE);
   assign out_valid     = (r_count != 2'd0);
   assign out_data      = (r_count != 2'd0) ? r_buf_data[r_head] : '0;
   assign out_last      = w_head_last;
   assign busy          = (r_state != ST_IDLE);
   assign done          = r_done;
   assign words_written = r_words;

   // RAM pins: only driven active during a write handshake or a read issue
   assign mem_enable       = w_wr_fire || w_issue;
   assign mem_write_enable = w_wr_fire;
   assign mem_address      = r_ptr;
   assign mem_data_in      = w_wr_fire ? in_data : '0;

   // Sequencer state, pointers, read pipeline and output buffer
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_ptr           <= '0;
         r_remaining     <= '0;
         r_words         <= '0;
         r_done          <= 1'b0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_buf_data[0]   <= '0;
         r_buf_data[1]   <= '0;
         r_buf_last      <= 2'b00;
         r_head          <= 1'b0;
         r_count         <= 2'd0;
      end else begin
         r_done          <= 1'b0;
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_remaining == C_CNT_ONE);

         // capture the RAM word issued last cycle, release the head on pop
         if (r_inflight) begin
            r_buf_data[w_tail] <= mem_data_out;
            r_buf_last[w_tail] <= r_inflight_last;
         end
         r_count <= r_count - {1'b0, w_pop} + {1'b0, r_inflight};
         if (w_pop) begin
            r_head <= ~r_head;
         end

         case (r_state)
            ST_IDLE: begin
               // write takes priority when both commands arrive together
               if (start_write) begin
                  r_state <= ST_WRITE;
                  r_ptr   <= write_base;
                  r_words <= '0;
               end else if (start_read) begin
                  r_state     <= ST_READ;
                  r_ptr       <= read_base;
                  r_remaining <= read_count;
               end
            end

            ST_WRITE: begin
               if (w_wr_fire) begin
                  r_ptr   <= r_ptr + C_PTR_ONE;
                  r_words <= r_words + C_CNT_ONE;
                  // stop on the marked word or once the whole RAM is filled
                  if (in_last || (r_words == C_DEPTH_M1)) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end

            ST_READ: begin
               if (w_issue) begin
                  r_ptr       <= r_ptr + C_PTR_ONE;
                  r_remaining <= r_remaining - C_CNT_ONE;
               end
               if (w_pop && w_head_last) begin
                  r_state    <= ST_IDLE;
                  r_done     <= 1'b1;
                  r_count    <= 2'd0;
                  r_inflight <= 1'b0;
               end else if ((r_remaining == '0) && (r_count == 2'd0) &&
                            !r_inflight) begin
                  // only reachable for a zero-length read
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/spwf_memory_sequencer.md
# spwf_memory_sequencer

Initiator-side sequencer for the 1024 x 16 single-port write-first block RAM used as the miner's message/nonce scratch store. It accepts a stream of 16-bit words over a valid/ready handshake and writes them to consecutive RAM addresses. On command, it reads a range back out and streams it to the hash datapath over a second valid/ready handshake. It is the only master of the RAM's enable/write_enable/address/data_in pins and absorbs the RAM's one-cycle registered read latency with a 2-entry output buffer.

## Interface
- ADDR_WIDTH, 10, RAM address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 16, word width.
- clock  in  1  rising-edge clock for all logic.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- start_write  in  1  one-cycle command; honoured only in IDLE.
- write_base  in  ADDR_WIDTH  first write address, sampled with start_write.
- in_valid / in_ready  in / out  1  write-stream handshake.
- in_data  in  DATA_WIDTH  write word.
- in_last  in  1  marks the final write word.
- start_read  in  1  one-cycle command; honoured only in IDLE.
- read_base  in  ADDR_WIDTH  first read address, sampled with start_read.
- read_count  in  ADDR_WIDTH+1  words to read, 0..1024, sampled with start_read.
- out_valid / out_ready  out / in  1  read-stream handshake.
- out_data  out  DATA_WIDTH  read word.
- out_last  out  1  high with the final read word.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when an operation completes.
- words_written  out  ADDR_WIDTH+1  count of words written by the last write operation.
- mem_enable, mem_write_enable  out  1  to RAM enable / write_enable.
- mem_address  out  ADDR_WIDTH  to RAM address.
- mem_data_in  out  DATA_WIDTH  to RAM data_in.
- mem_data_out  in  DATA_WIDTH  from RAM data_out; valid the cycle after a read enable.

## Operation
- States: IDLE, WRITE, READ.
- IDLE:
  - start_write moves to WRITE, loads ptr=write_base and clears words_written.
  - Otherwise start_read moves to READ, loads ptr=read_base and remaining=read_count.
  - If both commands are high in the same cycle, write wins and start_read is dropped.
  - Commands outside IDLE are ignored.
- WRITE:
  - in_ready=1.
  - On in_valid&&in_ready, drive mem_enable=1, mem_write_enable=1, mem_address=ptr, mem_data_in=in_data combinationally in that cycle. ptr increments mod 2^ADDR_WIDTH; words_written increments.
  - Exit to IDLE with a done pulse after accepting a word with in_last=1, or after the 1024th accepted word, whichever comes first.
  - The address wraps 1023->0 within an operation.
- READ:
  - mem_write_enable=0.
  - A read is issued (mem_enable=1, mem_address=ptr) only when remaining>0 and buffer occupancy + reads in flight < 2. Each issue decrements remaining and increments ptr, wrapping 1023->0.
  - mem_data_out is pushed into the buffer on the edge following the issue.
  - out_valid = buffer not empty; out_data = buffer head.
  - out_last is high on the word that is the read_count-th word of the operation.
  - Exit to IDLE with a done pulse on the out_last handshake.
  - read_count=0 returns to IDLE at the next edge with a done pulse; no reads are issued and out_valid is never raised.
- Outside an active write handshake or read issue: mem_enable=0, mem_write_enable=0, mem_address=ptr, mem_data_in=0.

## Timing
- Reset values: state=IDLE, buffer empty, and all outputs 0 (in_ready, out_valid, out_last, busy, done, words_written, mem_*, out_data).
- Reset mid-operation aborts immediately; data in the buffer and any read in flight are discarded.
- Write path: zero added latency. A word accepted at edge k is in RAM after edge k. Throughput is 1 word/cycle.
- Read path:
  - start_read sampled at edge k: first issue in the cycle after k, first out_valid=1 after edge k+2.
  - With out_ready held high, throughput is 1 word/cycle.
  - With out_ready low, at most 2 words are buffered and issue stalls. No word is lost or duplicated.
  - out_data and out_valid are held stable while out_valid && !out_ready.
- done is registered: high for exactly one cycle following the completing edge, while state is already IDLE. A new start_* is accepted in that same cycle.
- busy falls on the same edge on which done rises.

## Test plan
- Write then read: write_base=0x3FE, words 0xA000..0xA003 with in_last on the 4th -> RAM[0x3FE]=0xA000, RAM[0x3FF]=0xA001, RAM[0]=0xA002, RAM[1]=0xA003, words_written=4. Reading base 0x3FE, count 4 returns the same sequence with out_last on 0xA003.
- Full-depth write: 1024 words with no in_last -> auto exit after 1024 words, done pulse, words_written=1024, in_ready=0 afterwards.
- Read backpressure: count 8, out_ready toggled randomly -> exactly 8 handshakes in address order, out_data stable while stalled, never more than 2 reads outstanding.
- Latency: start_read at edge k with out_ready=1 -> out_valid first high after edge k+2; 16 words complete in 16 consecutive cycles.
- Corner commands:
  - start_write and start_read together -> WRITE only.
  - read_count=0 -> done one cycle later, out_valid never high.
  - start_read while busy -> ignored.
- Reset mid-read with the buffer full -> all outputs 0 next cycle and state IDLE. A following read of count 2 returns correct data.
